// File: rtl/ifu_fetch.sv
// Instruction fetch: owns PC, drives imem address, loads IF/ID, MIPS single delay slot; FETCH_ADDR_CHECK_EN adds target checking.
// Latency: imem word at im_addr in cycle n is on id_instr after edge n; redirects load the PC at the same edge.
// Backpressure: stall holds PC, IF/ID and fetch_cnt; flush bubbles IF/ID while the PC keeps advancing.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rd,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic        fetch_fault
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;
  logic        bad_target;
  logic        fault_q;

  assign im_addr     = pc;
  assign fetch_fault = fault_q;

  // Targets come from the instruction in ID; the word now in IF is its delay slot.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_target = id_pc + 32'd4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    j_target  = {id_pc[31:28], id_instr[25:0], 2'b00};
    npc       = pc_plus4;
    if (id_valid) begin
      case (npc_sel)
        2'b01:   npc = br_taken ? br_target : pc_plus4;
        2'b10:   npc = j_target;
        2'b11:   npc = rs_val;
        default: npc = pc_plus4;
      endcase
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] IM_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
  assign bad_target = (npc[1:0] != 2'b00) || (npc < RESET_PC) || (npc > IM_LAST);
`else
  assign bad_target = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      id_instr  <= 32'd0;
      id_pc     <= 32'd0;
      id_pc8    <= 32'd8;
      id_valid  <= 1'b0;
      fetch_cnt <= 32'd0;
      fault_q   <= 1'b0;
    end else if (fault_q) begin
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_pc8   <= 32'd8;
      id_valid <= 1'b0;
    end else if (stall) begin
      pc <= pc;
    end else if (bad_target) begin
      // PC keeps its value; the fault freezes fetch until reset.
      fault_q  <= 1'b1;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_pc8   <= 32'd8;
      id_valid <= 1'b0;
    end else if (flush) begin
      pc       <= npc;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_pc8   <= 32'd8;
      id_valid <= 1'b0;
    end else begin
      pc        <= npc;
      id_instr  <= im_rd;
      id_pc     <= pc;
      id_pc8    <= pc + 32'd8;
      id_valid  <= 1'b1;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a per-cycle behavioural fetch model.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_ifu_fetch;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam int          W    = 1024;
  localparam logic [31:0] LAST = RPC + 32'(4 * W - 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr, im_rd, rs_val;
  logic        stall, flush, br_taken;
  logic [1:0]  npc_sel;
  logic [31:0] id_instr, id_pc, id_pc8, fetch_cnt;
  logic        id_valid, fetch_fault;

  logic [31:0] mem [W];
  int vecs = 0;
  int errs = 0;

  logic [31:0] m_pc, m_instr, m_idpc, m_idpc8, m_cnt;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RPC), .IM_WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd(im_rd),
    .stall(stall), .flush(flush), .npc_sel(npc_sel), .br_taken(br_taken),
    .rs_val(rs_val), .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt), .fetch_fault(fetch_fault)
  );

  // Out-of-window addresses return a hash so wild jumps still fetch something.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] off;
    off = a - RPC;
    if (a >= RPC && off < 32'(4 * W)) return mem[off[11:2]];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  assign im_rd = imem(im_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = 0; m_idpc = 0; m_idpc8 = 8; m_valid = 0; m_cnt = 0; m_fault = 0;
  endtask

  task automatic model_bubble();
    m_instr = 0; m_idpc = 0; m_idpc8 = 8; m_valid = 0;
  endtask

  task automatic check_all();
    chk("im_addr", im_addr, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_idpc);
    chk("id_pc8", id_pc8, m_idpc8);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("fetch_cnt", fetch_cnt, m_cnt);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  // One clock: drive inputs at negedge, predict, take the edge, check at next negedge.
  task automatic step(input logic s, input logic f, input logic [1:0] sel,
                      input logic b, input logic [31:0] rs);
    logic [31:0]        tgt, word;
    logic signed [31:0] disp;
    logic               bad;
    stall = s; flush = f; npc_sel = sel; br_taken = b; rs_val = rs;
    word = imem(m_pc);
    disp = $signed(m_instr[15:0]);
    tgt  = m_pc + 4;
    if (m_valid) begin
      if (sel == 2'd1 && b)  tgt = m_idpc + 4 + 32'(disp * 4);
      else if (sel == 2'd2)  tgt = {m_idpc[31:28], m_instr[25:0], 2'b00};
      else if (sel == 2'd3)  tgt = rs;
    end
`ifdef FETCH_ADDR_CHECK_EN
    bad = (tgt % 4 != 0) || (tgt < RPC) || (tgt > LAST);
`else
    bad = 1'b0;
`endif
    @(posedge clk);
    if (m_fault) model_bubble();
    else if (s) begin end
    else if (bad) begin m_fault = 1; model_bubble(); end
    else if (f) begin model_bubble(); m_pc = tgt; end
    else begin
      m_instr = word; m_idpc = m_pc; m_idpc8 = m_pc + 8; m_valid = 1;
      m_pc = tgt; m_cnt = m_cnt + 1;
    end
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    logic [31:0] rs;
    for (int i = 0; i < W; i++) mem[i] = $urandom;
    mem[2] = 32'h1000_0004;
    stall = 0; flush = 0; npc_sel = 0; br_taken = 0; rs_val = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    check_all();

    repeat (3) step(0, 0, 2'd0, 0, 0);
    chk("seq_addr", im_addr, 32'h0000_300C);
    chk("seq_idpc", id_pc, 32'h0000_3008);
    chk("seq_cnt", fetch_cnt, 32'd3);

    step(0, 0, 2'd1, 1, 0);
    chk("beq_target", im_addr, 32'h0000_301C);
    chk("beq_slot", id_pc, 32'h0000_300C);

    step(0, 0, 2'd3, 0, 32'h0000_3040);
    chk("jr_target", im_addr, 32'h0000_3040);
    chk("jr_slot", id_pc, 32'h0000_301C);

    repeat (3) step(1, 0, 2'd2, 0, 0);
    step(0, 0, 2'd2, 0, 0);
    step(1, 1, 2'd0, 0, 0);
    step(0, 1, 2'd0, 0, 0);
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_instr", id_instr, 32'd0);

`ifdef FETCH_ADDR_CHECK_EN
    step(0, 0, 2'd0, 0, 0);
    step(0, 0, 2'd3, 0, RPC + 32'd2);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    step(0, 0, 2'd0, 0, 0);
`endif
    reset_pulse();
    chk("restart_addr", im_addr, RPC);

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) reset_pulse();
      rs = ($urandom % 16 == 0) ? RPC + 32'd2 : RPC + 32'(4 * $urandom_range(0, W - 1));
      step($urandom % 5 == 0, $urandom % 8 == 0, 2'($urandom), 1'($urandom), rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
